wb_intercon_reg: RTL and testbench
==================================

// Module: wb_intercon_reg
// PURPOSE
//  Registered, error-reporting successor to the combinational Wishbone slave decoder. Sits between the
//  management core's single Wishbone master and NS slaves (RAM, flash, UART, GPIO, sysctl, flash-cfg, ...).
//  It registers the decode and the response path, holds a per-transaction state machine, and terminates
//  unmapped or (optionally) hung accesses with wbm_err_o instead of stalling the core forever.
// PARAMETERS
//  DW         32            data width (multiple of 8)
//  AW         32            address width
//  NS         6             number of slaves
//  ADR_MASK   NS*AW vector  per-slave decode mask; slice i = bits [(i+1)*AW-1:i*AW]; default 32'hFF00_0000 each
//  IFACE_ADR  NS*AW vector  per-slave base; default {2800_0000,2200_0000,2100_0000,2000_0000,1000_0000,0000_0000}
//  TO_W       8             timeout counter width
//  TO_CYCLES  255           cycles in REQ before timeout error (1..2^TO_W-1)
// PORTS
//  wb_clk_i   in   1      clock; all logic on rising edge
//  wb_rstn_i  in   1      asynchronous active-low reset
//  wbm_adr_i  in   AW     master address
//  wbm_dat_i  in   DW     master write data
//  wbm_sel_i  in   DW/8   byte selects
//  wbm_we_i   in   1      write enable
//  wbm_cyc_i  in   1      cycle valid
//  wbm_stb_i  in   1      strobe
//  wbm_dat_o  out  DW     registered read data
//  wbm_ack_o  out  1      registered ack, one-cycle pulse
//  wbm_err_o  out  1      registered error, one-cycle pulse (decode miss / timeout)
//  wbs_adr_o  out  AW     registered address, broadcast to all slaves
//  wbs_dat_o  out  DW     registered write data, broadcast
//  wbs_sel_o  out  DW/8   registered byte selects, broadcast
//  wbs_we_o   out  1      registered write enable, broadcast
//  wbs_cyc_o  out  NS     one-hot cycle to selected slave
//  wbs_stb_o  out  NS     one-hot strobe to selected slave
//  wbs_dat_i  in   NS*DW  slave read data, slice i from slave i
//  wbs_ack_i  in   NS     slave acks
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; every output, timer and register = 0.
//  - Decode: hit[i] = (wbm_adr_i & mask_i) == base_i; multiple hits -> lowest index wins; no hit -> miss.
//  - IDLE: on cyc&stb latch adr/dat/sel/we and one-hot select; hit -> REQ, miss -> ERR.
//  - REQ: wbs_cyc_o/wbs_stb_o[sel] = 1 with latched bus held stable; timer increments each cycle.
//    ack_i[sel] -> capture wbs_dat_i[sel] into wbm_dat_o, drop slave cyc/stb, -> RESP.
//    Master drops cyc or stb (abort) -> drop slave cyc/stb, no ack/err, -> IDLE (abort beats same-cycle ack).
//  - RESP: wbm_ack_o = 1 exactly one cycle -> IDLE. ERR: wbm_err_o = 1 exactly one cycle, wbm_dat_o = 0 -> IDLE.
//  - Latency: request seen in cycle 0 -> slave stb in cycle 1; slave ack in cycle k -> wbm_ack_o in cycle k+1.
//    Decode miss: wbm_err_o in cycle 1. Minimum transfer = 3 cycles; next request accepted in the cycle after RESP/ERR.
//  - ack_i from non-selected slaves, or while not in REQ, is ignored. wbm_dat_o holds its value outside RESP.
//  - wbm_ack_o and wbm_err_o are never asserted together. wbs_stb_o is never multi-hot.
//  - Reset mid-transaction: immediate return to IDLE, pending ack is lost, slave strobes drop asynchronously.
// CONFIGURATION
//  WB_INTERCON_TIMEOUT_EN defined: in REQ, when timer == TO_CYCLES with no ack -> drop slave cyc/stb, -> ERR.
//    An ack arriving in that same cycle wins (-> RESP).
//  Not defined: no timer logic; REQ waits for ack or abort indefinitely; TO_W/TO_CYCLES are unused.
// STRUCTURE
//  wb_intercon_pkg: state encoding (IDLE, REQ, RESP, ERR), default ADR_MASK/IFACE_ADR map constants.
//  Sub-module wb_addr_decoder: combinational; outputs priority one-hot select plus miss flag; reused by other buses.
//  Top: FSM, latched request registers, response mux/register, optional timer.
// TESTING
//  1 Read 0x2100_0004, GPIO acks in its 2nd strobe cycle with 0xDEAD_BEEF -> wbm_ack_o 1 cycle later, dat = 0xDEAD_BEEF.
//  2 Write 0x0000_0010, dat 0x1234_5678, sel 4'b0011 -> only wbs_stb_o[0] high; bus stable until ack; single ack pulse.
//  3 Access 0x3000_0000 (unmapped) -> no wbs_stb_o; wbm_err_o in cycle 1; wbm_dat_o = 0.
//  4 TIMEOUT_EN, TO_CYCLES=4, slave 3 never acks -> stb held 4 cycles, then drops; wbm_err_o next cycle.
//  5 Master drops stb in REQ while slave 1 acks the same cycle -> no wbm_ack_o; FSM back in IDLE.
//  6 wb_rstn_i low in REQ -> all outputs 0 without waiting for a clock; after release, a new read succeeds.

Source files
------------

// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the registered Wishbone interconnect:
// transaction state encoding and the default management-SoC address map.
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_t;

  localparam int unsigned DEF_NS = 6;
  localparam int unsigned DEF_AW = 32;

  // Slice i occupies bits [(i+1)*AW-1 : i*AW]
  localparam logic [DEF_NS*DEF_AW-1:0] DEF_ADR_MASK = {DEF_NS{32'hFF00_0000}};
  localparam logic [DEF_NS*DEF_AW-1:0] DEF_IFACE_ADR = {
    32'h2800_0000,  // slave 5
    32'h2200_0000,  // slave 4
    32'h2100_0000,  // slave 3
    32'h2000_0000,  // slave 2
    32'h1000_0000,  // slave 1
    32'h0000_0000   // slave 0
  };

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational priority address decoder: one-hot slave select, lowest
// matching index wins, miss flag when no slave window matches.
module wb_addr_decoder #(
  parameter int unsigned           AW        = 32,
  parameter int unsigned           NS        = 6,
  parameter logic [NS*AW-1:0]      ADR_MASK  = wb_intercon_pkg::DEF_ADR_MASK,
  parameter logic [NS*AW-1:0]      IFACE_ADR = wb_intercon_pkg::DEF_IFACE_ADR
) (
  input  logic [AW-1:0] adr,
  output logic [NS-1:0] sel,
  output logic          miss
);

  // Scan upward; the first hit claims the select and blocks later ones
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int unsigned i = 0; i < NS; i++) begin
      if (miss && ((adr & ADR_MASK[i*AW +: AW]) == IFACE_ADR[i*AW +: AW])) begin
        sel[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_intercon_reg.sv
// Registered Wishbone single-master / NS-slave interconnect.
// Decode and response paths are registered; unmapped accesses end with
// wbm_err_o. Optional REQ-phase timeout enabled by WB_INTERCON_TIMEOUT_EN.
module wb_intercon_reg
  import wb_intercon_pkg::*;
#(
  parameter int unsigned      DW        = 32,
  parameter int unsigned      AW        = 32,
  parameter int unsigned      NS        = 6,
  parameter logic [NS*AW-1:0] ADR_MASK  = DEF_ADR_MASK,
  parameter logic [NS*AW-1:0] IFACE_ADR = DEF_IFACE_ADR,
  parameter int unsigned      TO_W      = 8,
  parameter int unsigned      TO_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rstn_i,
  input  logic [AW-1:0]      wbm_adr_i,
  input  logic [DW-1:0]      wbm_dat_i,
  input  logic [DW/8-1:0]    wbm_sel_i,
  input  logic               wbm_we_i,
  input  logic               wbm_cyc_i,
  input  logic               wbm_stb_i,
  output logic [DW-1:0]      wbm_dat_o,
  output logic               wbm_ack_o,
  output logic               wbm_err_o,
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [DW/8-1:0]    wbs_sel_o,
  output logic               wbs_we_o,
  output logic [NS-1:0]      wbs_cyc_o,
  output logic [NS-1:0]      wbs_stb_o,
  input  logic [NS*DW-1:0]   wbs_dat_i,
  input  logic [NS-1:0]      wbs_ack_i
);

  // Reject an unreachable timeout setting at elaboration
  if (TO_CYCLES < 1 || TO_CYCLES >= (64'd1 << TO_W)) begin : g_bad_to
    $error("wb_intercon_reg: TO_CYCLES out of range for TO_W");
  end

  wb_state_t         state_q, state_d;
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     wdat_q;
  logic [DW/8-1:0]   sel_q;
  logic              we_q;
  logic [NS-1:0]     slv_q;
  logic [DW-1:0]     rdat_q;
  logic              ack_q;
  logic              err_q;

  logic [NS-1:0]     dec_sel;
  logic              dec_miss;
  logic              req;
  logic              ack_hit;
  logic [DW-1:0]     rdat_mux;
  logic              timeout;

  wb_addr_decoder #(
    .AW        (AW),
    .NS        (NS),
    .ADR_MASK  (ADR_MASK),
    .IFACE_ADR (IFACE_ADR)
  ) u_dec (
    .adr  (wbm_adr_i),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  assign req     = wbm_cyc_i & wbm_stb_i;
  assign ack_hit = |(wbs_ack_i & slv_q);

  // Read-data mux driven by the latched one-hot select
  always_comb begin
    rdat_mux = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (slv_q[i]) rdat_mux = rdat_mux | wbs_dat_i[i*DW +: DW];
    end
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  logic [TO_W-1:0] timer_q;

  // Timer holds 1 in the first REQ cycle so the strobe lasts exactly TO_CYCLES cycles
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i)              timer_q <= '0;
    else if (state_q != ST_REQ)  timer_q <= TO_W'(1);
    else                         timer_q <= timer_q + TO_W'(1);
  end

  assign timeout = (timer_q == TO_W'(TO_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // Next-state: abort beats ack, ack beats timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = dec_miss ? ST_ERR : ST_REQ;
      ST_REQ: begin
        if (!req)         state_d = ST_IDLE;
        else if (ack_hit) state_d = ST_RESP;
        else if (timeout) state_d = ST_ERR;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Latch the master request in IDLE; held stable for the whole slave phase
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      adr_q  <= '0;
      wdat_q <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
    end else if (state_q == ST_IDLE && req) begin
      adr_q  <= wbm_adr_i;
      wdat_q <= wbm_dat_i;
      sel_q  <= wbm_sel_i;
      we_q   <= wbm_we_i;
    end
  end

  // Slave select is live only while the next state is REQ
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i)              slv_q <= '0;
    else if (state_d != ST_REQ)  slv_q <= '0;
    else if (state_q == ST_IDLE) slv_q <= dec_sel;
  end

  // Response registers: single-cycle ack/err pulses, read data held between responses
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q <= (state_d == ST_RESP);
      err_q <= (state_d == ST_ERR);
      if (state_d == ST_RESP)     rdat_q <= rdat_mux;
      else if (state_d == ST_ERR) rdat_q <= '0;
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = wdat_q;
  assign wbs_sel_o = sel_q;
  assign wbs_we_o  = we_q;
  assign wbs_cyc_o = slv_q;
  assign wbs_stb_o = slv_q;

endmodule

// File: tb/tb_wb_intercon_reg.sv
// Scoreboard bench for wb_intercon_reg. Timeout scenario runs only when
// WB_INTERCON_TIMEOUT_EN is defined (DUT built with TO_CYCLES = 4).
module tb_wb_intercon_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NS = 6;
`ifdef WB_INTERCON_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     m_adr = '0;
  logic [DW-1:0]     m_dat = '0;
  logic [DW/8-1:0]   m_sel = '0;
  logic              m_we = 1'b0;
  logic              m_cyc = 1'b0;
  logic              m_stb = 1'b0;
  logic [DW-1:0]     m_rdat;
  logic              m_ack, m_err;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_wdat;
  logic [DW/8-1:0]   s_sel;
  logic              s_we;
  logic [NS-1:0]     s_cyc, s_stb;
  logic [NS*DW-1:0]  s_rdat = '0;
  logic [NS-1:0]     s_ack = '0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  wb_intercon_reg #(
    .DW        (DW),
    .AW        (AW),
    .NS        (NS),
    .TO_W      (8),
    .TO_CYCLES (TB_TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_dat),
    .wbm_sel_i (m_sel),
    .wbm_we_i  (m_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_dat_o (m_rdat),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_wdat),
    .wbs_sel_o (s_sel),
    .wbs_we_o  (s_we),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_dat_i (s_rdat),
    .wbs_ack_i (s_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every response pulse, plus per-cycle invariants
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if ((m_ack && m_err) || ($countones(s_stb) > 1) || (s_stb != s_cyc)) begin
        fails++;
        $display("FAIL invariant: ack=%b err=%b stb=%b cyc=%b at %0t", m_ack, m_err, s_stb, s_cyc, $time);
      end
      if (m_ack || m_err) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: got ack=%b err=%b expected none at %0t", m_ack, m_err, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_err !== e.err || m_ack !== !e.err || m_rdat !== e.dat) begin
            fails++;
            $display("FAIL resp: got err=%b ack=%b dat=%h expected err=%b dat=%h at %0t",
                     m_err, m_ack, m_rdat, e.err, e.dat, $time);
          end
        end
      end
    end
  end

  // Full transfer; slv < 0 means an unmapped address
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int slv, input int n_ack, input logic [31:0] rdat);
    logic [NS-1:0] onehot;
    @(posedge clk); #1;
    m_adr = a; m_dat = d; m_sel = s; m_we = w; m_cyc = 1'b1; m_stb = 1'b1;
    if (slv < 0) sb.push_back('{err: 1'b1, dat: 32'h0});
    else         sb.push_back('{err: 1'b0, dat: rdat});
    @(posedge clk); #1;
    if (slv < 0) begin
      @(negedge clk);
      chk("miss_no_stb", 64'(s_stb), 64'd0);
      chk("miss_err_cycle1", 64'(m_err), 64'd1);
      m_cyc = 1'b0; m_stb = 1'b0;
      return;
    end
    onehot = '0;
    onehot[slv] = 1'b1;
    for (int j = 1; j <= n_ack; j++) begin
      if (j == n_ack) begin
        s_ack[slv] = 1'b1;
        s_rdat[slv*DW +: DW] = rdat;
      end else if (j == 1) begin
        s_ack[(slv + 1) % NS] = 1'b1;  // stray ack from a non-selected slave
      end
      @(negedge clk);
      chk("stb_onehot", 64'(s_stb), 64'(onehot));
      chk("adr_hold", 64'(s_adr), 64'(a));
      chk("wdat_hold", 64'(s_wdat), 64'(d));
      chk("sel_hold", 64'(s_sel), 64'(s));
      chk("we_hold", 64'(s_we), 64'(w));
      chk("no_early_ack", 64'(m_ack), 64'd0);
      @(posedge clk); #1;
      s_ack = '0;
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    chk("ack_latency", 64'(m_ack), 64'd1);
    chk("stb_dropped", 64'(s_stb), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) s_rdat[i*DW +: DW] = 32'hA0A0_0000 | 32'(i);

    // Reset state
    #12;
    chk("rst_stb", 64'(s_stb), 64'd0);
    chk("rst_ack_err", 64'({m_ack, m_err}), 64'd0);
    chk("rst_rdat", 64'(m_rdat), 64'd0);
    chk("rst_adr", 64'(s_adr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // GPIO read, ack in the second strobe cycle
    xfer(32'h2100_0004, 1'b0, 32'h0, 4'hF, 3, 2, 32'hDEAD_BEEF);
    // Write to slave 0 with partial byte selects, ack after 3 strobe cycles
    xfer(32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011, 0, 3, 32'hCAFE_0001);
    // Read data holds while idle
    repeat (2) @(negedge clk);
    chk("rdat_hold", 64'(m_rdat), 64'hCAFE_0001);
    // Unmapped address
    xfer(32'h3000_0000, 1'b0, 32'h0, 4'hF, -1, 0, 32'h0);

    // Acks while idle must be ignored
    @(posedge clk); #1;
    s_ack = '1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_ack_ignored", 64'({m_ack, m_err}), 64'd0);
    s_ack = '0;

    // Abort: master drops stb in the same cycle slave 1 acks
    @(posedge clk); #1;
    m_adr = 32'h1000_0020; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_stb", 64'(s_stb), 64'h2);
    @(posedge clk); #1;
    m_stb = 1'b0; m_cyc = 1'b0; s_ack[1] = 1'b1;
    @(negedge clk);
    chk("abort_no_ack_a", 64'(m_ack), 64'd0);
    @(posedge clk); #1;
    s_ack = '0;
    @(negedge clk);
    chk("abort_no_ack_b", 64'({m_ack, m_err}), 64'd0);
    chk("abort_stb_drop", 64'(s_stb), 64'd0);

    // Single-cycle ack right after the abort proves the FSM is idle
    xfer(32'h28AB_CDEF, 1'b0, 32'h0, 4'hF, 5, 1, 32'h5555_AAAA);

    // Reset in REQ: outputs clear without a clock edge
    @(posedge clk); #1;
    m_adr = 32'h2000_0100; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_stb", 64'(s_stb), 64'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stb", 64'({s_stb, s_cyc}), 64'd0);
    chk("async_rst_bus", 64'({s_adr, s_we, s_sel}), 64'd0);
    chk("async_rst_rdat", 64'(m_rdat), 64'd0);
    chk("async_rst_resp", 64'({m_ack, m_err}), 64'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer(32'h2200_0008, 1'b0, 32'h0, 4'hF, 4, 2, 32'h0BAD_F00D);

`ifdef WB_INTERCON_TIMEOUT_EN
    // Slave 3 never acks: strobe for TO_CYCLES cycles, then error
    begin
      int cnt;
      cnt = 0;
      @(posedge clk); #1;
      m_adr = 32'h2100_0000; m_cyc = 1'b1; m_stb = 1'b1;
      sb.push_back('{err: 1'b1, dat: 32'h0});
      @(posedge clk); #1;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (s_stb[3]) cnt++;
        else break;
        @(posedge clk); #1;
      end
      chk("to_stb_cycles", 64'(cnt), 64'd4);
      chk("to_err", 64'(m_err), 64'd1);
      m_cyc = 1'b0; m_stb = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
